// File: rtl/ticket_vend_sequencer.sv
// Ticket vending sequencer: collects coin credit, sells one ticket through the
// printer handshake, then returns change (or a full refund) through the hopper.
module ticket_vend_sequencer #(
  parameter int unsigned FARE_HOWRAH    = 5,
  parameter int unsigned FARE_MANIKARAN = 10,
  parameter int unsigned FARE_ESPLANADE = 15,
  parameter int unsigned CREDIT_W       = 6,
  parameter int unsigned MAX_CREDIT     = 40,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [4:0]          coin,
  input  logic [1:0]          choice,
  input  logic                cancel,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                tkt_req,
  output logic [1:0]          tkt_sel,
  input  logic                tkt_ack,
  output logic                pay_req,
  output logic [4:0]          pay_coin,
  input  logic                pay_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_PAYOUT  = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   idle_cnt_r;

  logic [CREDIT_W-1:0] fare_s;
  logic                choice_ok_s;
  logic                coin_ok_s;
  logic [CREDIT_W:0]   sum_s;
  logic [4:0]          pay_next_s;
  logic                timeout_s;

  // Fare lookup, coin legality/cap check and next payout coin selection.
  always_comb begin
    fare_s      = {CREDIT_W{1'b0}};
    sum_s       = (CREDIT_W+1)'(credit) + (CREDIT_W+1)'(coin);
    coin_ok_s   = 1'b0;
    choice_ok_s = 1'b0;
    pay_next_s  = 5'd5;
    timeout_s   = 1'b0;
    case (choice)
      2'b01:   fare_s = CREDIT_W'(FARE_HOWRAH);
      2'b10:   fare_s = CREDIT_W'(FARE_MANIKARAN);
      2'b11:   fare_s = CREDIT_W'(FARE_ESPLANADE);
      default: fare_s = {CREDIT_W{1'b0}};
    endcase
    if ((coin == 5'd5) || (coin == 5'd10) || (coin == 5'd20)) begin
      coin_ok_s = (sum_s <= (CREDIT_W+1)'(MAX_CREDIT));
    end else begin
      coin_ok_s = 1'b0;
    end
    if (choice != 2'b00) begin
      choice_ok_s = (credit >= fare_s);
    end else begin
      choice_ok_s = 1'b0;
    end
    if (credit >= CREDIT_W'(10)) begin
      pay_next_s = 5'd10;
    end else begin
      pay_next_s = 5'd5;
    end
    if (idle_cnt_r >= CNT_W'(TIMEOUT - 1)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Sale sequencer: state, credit, idle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idle_cnt_r  <= {CNT_W{1'b0}};
      credit      <= {CREDIT_W{1'b0}};
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      tkt_req     <= 1'b0;
      tkt_sel     <= 2'b00;
      pay_req     <= 1'b0;
      pay_coin    <= 5'd0;
      busy        <= 1'b0;
    end else begin
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      case (state_r)
        ST_IDLE, ST_COLLECT: begin
          if (coin_valid) begin
            // A coin always wins over cancel/choice/timeout in this cycle.
            if (coin_ok_s) begin
              credit      <= sum_s[CREDIT_W-1:0];
              coin_accept <= 1'b1;
              state_r     <= ST_COLLECT;
              idle_cnt_r  <= {CNT_W{1'b0}};
            end else begin
              coin_reject <= 1'b1;
              if ((state_r == ST_COLLECT) && (idle_cnt_r < CNT_W'(TIMEOUT))) begin
                idle_cnt_r <= idle_cnt_r + CNT_W'(1);
              end
            end
          end else if (state_r == ST_COLLECT) begin
            if (cancel || (!choice_ok_s && timeout_s)) begin
              // Full refund; credit is nonzero in COLLECT.
              state_r    <= ST_PAYOUT;
              busy       <= 1'b1;
              pay_req    <= 1'b1;
              pay_coin   <= pay_next_s;
              idle_cnt_r <= {CNT_W{1'b0}};
            end else if (choice_ok_s) begin
              state_r    <= ST_ISSUE;
              busy       <= 1'b1;
              credit     <= credit - fare_s;
              tkt_sel    <= choice;
              tkt_req    <= 1'b1;
              idle_cnt_r <= {CNT_W{1'b0}};
            end else begin
              idle_cnt_r <= idle_cnt_r + CNT_W'(1);
            end
          end else begin
            idle_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_ISSUE: begin
          if (coin_valid) begin
            coin_reject <= 1'b1;
          end
          if (tkt_ack) begin
            tkt_req <= 1'b0;
            if (credit != {CREDIT_W{1'b0}}) begin
              state_r  <= ST_PAYOUT;
              pay_req  <= 1'b1;
              pay_coin <= pay_next_s;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        ST_PAYOUT: begin
          if (coin_valid) begin
            coin_reject <= 1'b1;
          end
          if (pay_req) begin
            if (pay_ack) begin
              credit  <= credit - CREDIT_W'(pay_coin);
              pay_req <= 1'b0;
            end
          end else if (credit != {CREDIT_W{1'b0}}) begin
            // pay_req has been low for one cycle; coin may change now.
            pay_req  <= 1'b1;
            pay_coin <= pay_next_s;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          tkt_req <= 1'b0;
          pay_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ticket_vend_sequencer.sv
// Directed, table-driven bench for ticket_vend_sequencer.
module tb_ticket_vend_sequencer;

  localparam int T = 255;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [4:0] coin;
  logic [1:0] choice;
  logic       cancel;
  logic       coin_accept;
  logic       coin_reject;
  logic       tkt_req;
  logic [1:0] tkt_sel;
  logic       tkt_ack;
  logic       pay_req;
  logic [4:0] pay_coin;
  logic       pay_ack;
  logic [5:0] credit;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ticket_vend_sequencer #(
    .FARE_HOWRAH(5), .FARE_MANIKARAN(10), .FARE_ESPLANADE(15),
    .CREDIT_W(6), .MAX_CREDIT(40), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin), .choice(choice),
    .cancel(cancel), .coin_accept(coin_accept), .coin_reject(coin_reject),
    .tkt_req(tkt_req), .tkt_sel(tkt_sel), .tkt_ack(tkt_ack), .pay_req(pay_req),
    .pay_coin(pay_coin), .pay_ack(pay_ack), .credit(credit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cv, cn, ch, can, tack, pack;
    int acc, rej, treq, tsel, preq, pcoin, cr, bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int cv, cn, ch, can, tack, pack,
                              input int acc, rej, treq, tsel, preq, pcoin, cr, bsy);
    vec_t v;
    v.cv = cv; v.cn = cn; v.ch = ch; v.can = can; v.tack = tack; v.pack = pack;
    v.acc = acc; v.rej = rej; v.treq = treq; v.tsel = tsel;
    v.preq = preq; v.pcoin = pcoin; v.cr = cr; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the clock edge.
  task automatic apply(input int cv, cn, ch, can, tack, pack);
    coin_valid = cv[0];
    coin       = cn[4:0];
    choice     = ch[1:0];
    cancel     = can[0];
    tkt_ack    = tack[0];
    pay_ack    = pack[0];
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string p, input int acc, rej, treq, tsel, preq, pcoin, cr, bsy);
    chk({p, "_accept"}, int'(coin_accept), acc);
    chk({p, "_reject"}, int'(coin_reject), rej);
    chk({p, "_tkt_req"}, int'(tkt_req), treq);
    if (treq != 0) chk({p, "_tkt_sel"}, int'(tkt_sel), tsel);
    chk({p, "_pay_req"}, int'(pay_req), preq);
    if (preq != 0) chk({p, "_pay_coin"}, int'(pay_coin), pcoin);
    chk({p, "_credit"}, int'(credit), cr);
    chk({p, "_busy"}, int'(busy), bsy);
  endtask

  initial begin
    vec_t v;
    // Test 1: coin 10, choice 10, exact fare, no change
    tbl.push_back(mk(1,10,0,0,0,0, 1,0,0,0,0,0,10,0));
    tbl.push_back(mk(0,0,2,0,0,0,  0,0,1,2,0,0,0,1));
    tbl.push_back(mk(1,5,0,0,0,0,  0,1,1,2,0,0,0,1));   // coin during ISSUE rejected
    tbl.push_back(mk(0,0,0,0,1,0,  0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,3,1,1,1,  0,0,0,0,0,0,0,0));   // IDLE ignores all of these
    // Test 2: coin 20, howrah, change 10 then 5
    tbl.push_back(mk(1,20,0,0,0,0, 1,0,0,0,0,0,20,0));
    tbl.push_back(mk(0,0,1,0,0,0,  0,0,1,1,0,0,15,1));
    tbl.push_back(mk(0,0,0,0,1,0,  0,0,0,0,1,10,15,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,1,10,15,1));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0,0,5,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,1,5,5,1));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,0,0,0,0));
    // Test 3: credit cap and illegal coin, then refund of 40
    tbl.push_back(mk(1,20,0,0,0,0, 1,0,0,0,0,0,20,0));
    tbl.push_back(mk(1,20,0,0,0,0, 1,0,0,0,0,0,40,0));
    tbl.push_back(mk(1,5,0,0,0,0,  0,1,0,0,0,0,40,0));
    tbl.push_back(mk(1,7,0,0,0,0,  0,1,0,0,0,0,40,0));
    tbl.push_back(mk(0,0,0,1,0,0,  0,0,0,0,1,10,40,1));
    tbl.push_back(mk(1,10,0,0,0,1, 0,1,0,0,0,0,30,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,1,10,30,1));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0,0,20,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,1,10,20,1));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0,0,10,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,1,10,10,1));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,0,0,0,0));
    // Test 4: insufficient credit, cancel, coin beats cancel, cancel beats choice
    tbl.push_back(mk(1,5,0,0,0,0,  1,0,0,0,0,0,5,0));
    tbl.push_back(mk(0,0,3,0,0,0,  0,0,0,0,0,0,5,0));
    tbl.push_back(mk(0,0,0,1,0,0,  0,0,0,0,1,5,5,1));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,5,0,0,0,0,  1,0,0,0,0,0,5,0));
    tbl.push_back(mk(1,10,0,1,0,0, 1,0,0,0,0,0,15,0));
    tbl.push_back(mk(0,0,2,1,0,0,  0,0,0,0,1,10,15,1));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0,0,5,1));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,1,5,5,1));   // pay_ack while pay_req=0 ignored
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0,0,0,0,0));

    // Reset state
    rst = 1'b1;
    coin_valid = 1'b0; coin = 5'd0; choice = 2'b00; cancel = 1'b0;
    tkt_ack = 1'b0; pay_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0,0,0,0,0,0,0,0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      apply(v.cv, v.cn, v.ch, v.can, v.tack, v.pack);
      chk_all($sformatf("v%0d", i), v.acc, v.rej, v.treq, v.tsel, v.preq, v.pcoin, v.cr, v.bsy);
    end

    // Test 5: inactivity timeout refunds the credit
    apply(1,10,0,0,0,0);
    chk_all("to_coin", 1,0,0,0,0,0,10,0);
    for (int i = 1; i < T; i++) begin
      apply(0,0,0,0,0,0);
      chk($sformatf("to_wait%0d_pay_req", i), int'(pay_req), 0);
    end
    apply(0,0,0,0,0,0);
    chk_all("to_fire", 0,0,0,0,1,10,10,1);
    apply(0,0,0,0,0,1);
    chk_all("to_paid", 0,0,0,0,0,0,0,1);
    apply(0,0,0,0,0,0);
    chk_all("to_idle", 0,0,0,0,0,0,0,0);

    // Test 6: reset in the middle of ISSUE
    apply(1,10,0,0,0,0);
    chk_all("rs_coin", 1,0,0,0,0,0,10,0);
    apply(0,0,2,0,0,0);
    chk_all("rs_issue", 0,0,1,2,0,0,0,1);
    rst = 1'b1;
    apply(0,0,0,0,0,0);
    chk_all("rs_reset", 0,0,0,0,0,0,0,0);
    rst = 1'b0;
    apply(0,0,0,0,1,0);
    chk_all("rs_late_ack", 0,0,0,0,0,0,0,0);
    apply(1,5,0,0,0,0);
    chk_all("rs_coin2", 1,0,0,0,0,0,5,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
